// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: word width, the canonical NOP
// and the fetch fault-cause codes.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_RANGE    = 2'b01,
        FAULT_MISALIGN = 2'b10
    } fault_e;

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// Next-PC selection for the fetch stage (redirect / sequential / hold) plus the
// alignment and range classification of the current PC. MISALIGN_TRAP_EN selects trapping.
module pc_gen
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 128
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            load_i,
    output logic [XLEN-1:0] pc_next_o,
    output fault_e          fault_o
);

    localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(4);

    logic [XLEN-1:0] target_pc;
    logic            out_of_range;

    assign out_of_range = ({1'b0, pc_i} >= PC_LIMIT);

`ifdef MISALIGN_TRAP_EN
    // Keep the raw target so the next load can flag it; misalignment outranks range.
    assign target_pc = redirect_pc_i;

    always_comb begin
        fault_o = FAULT_NONE;
        if (pc_i[1:0] != 2'b00) begin
            fault_o = FAULT_MISALIGN;
        end else if (out_of_range) begin
            fault_o = FAULT_RANGE;
        end
    end
`else
    assign target_pc = redirect_pc_i & ~(XLEN'(3));

    always_comb begin
        fault_o = FAULT_NONE;
        if (out_of_range) begin
            fault_o = FAULT_RANGE;
        end
    end
`endif

    // A faulting PC never advances, so repeated loads re-report the same fault.
    always_comb begin
        pc_next_o = pc_i;
        if (redirect_valid_i) begin
            pc_next_o = target_pc;
        end else if (load_i && fault_o == FAULT_NONE) begin
            pc_next_o = pc_i + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register with valid/ready
// handoff to decode, and accepted-entry counter. Optional macro: MISALIGN_TRAP_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128,
    parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [1:0]  if_fault_cause,
    output logic [31:0] fetch_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    fault_e          cause_q, cause_d;
    logic [31:0]     count_q, count_d;

    logic            accept;
    logic            load;
    fault_e          load_fault;

    assign accept = if_valid_q & id_ready;
    assign load   = !redirect_valid & fetch_en & (!if_valid_q | id_ready);

    pc_gen #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_gen (
        .pc_i             (pc_q),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .load_i           (load),
        .pc_next_o        (pc_d),
        .fault_o          (load_fault)
    );

    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        cause_d    = cause_q;
        // Acceptance is counted even when a redirect flushes the entry this cycle.
        count_d    = count_q + {31'b0, accept};

        if (redirect_valid) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            cause_d    = FAULT_NONE;
        end else if (load) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            cause_d    = load_fault;
            if_instr_d = (load_fault == FAULT_NONE) ? imem_rdata : NOP_INSTR;
        end else if (accept) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            cause_q    <= FAULT_NONE;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
        end
    end

    assign imem_pc        = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_fault_cause = cause_q;
    assign fetch_count    = count_q;

endmodule
